// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the GRF hazard scoreboard: forward-mux encodings and the
// Tuse value that marks an operand as not read.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_W   = 2'd1,
        FWD_M   = 2'd2,
        FWD_E   = 2'd3
    } fwd_sel_e;

    localparam int TUSE_NONE = 3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage demand bundle plus the stall/forward results returned to the pipeline.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic [REG_AW-1:0] d_wa;
    logic [T_W-1:0]    d_tnew;
    logic              d_md;
    logic              md_busy;
    logic              stall;
    logic [1:0]        d_fwd_rs;
    logic [1:0]        d_fwd_rt;
    logic [1:0]        e_fwd_rs;
    logic [1:0]        e_fwd_rt;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, md_busy,
        input  stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_md, md_busy,
        output stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt
    );
endinterface

// File: rtl/hazard_scoreboard_port_check.sv
// Hazard and D-stage forward decision for one read operand against the E/M/W write tags.
module hazard_port_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic [REG_AW-1:0] r,
    input  logic [T_W-1:0]    tuse,
    input  logic [REG_AW-1:0] wa_e,
    input  logic [T_W-1:0]    tnew_e,
    input  logic [REG_AW-1:0] wa_m,
    input  logic [T_W-1:0]    tnew_m,
    input  logic [REG_AW-1:0] wa_w,
    output logic              hz,
    output logic [1:0]        fwd
);
    logic used;
    logic match_e;
    logic match_m;
    logic match_w;

    assign used    = (tuse != T_W'(TUSE_NONE));
    assign match_e = (r != '0) && (wa_e == r);
    assign match_m = (r != '0) && (wa_m == r);
    assign match_w = (r != '0) && (wa_w == r);

    // The youngest matching write decides; older ones behind it are shadowed.
    assign hz = used && ((match_e && (tnew_e > tuse)) ||
                         (!match_e && match_m && (tnew_m > tuse)));

    always_comb begin
        fwd = FWD_GRF;
        if (match_e) begin
            fwd = (tnew_e == '0) ? FWD_E : FWD_GRF;
        end else if (match_m) begin
            fwd = (tnew_m == '0) ? FWD_M : FWD_GRF;
        end else if (match_w) begin
            fwd = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// GRF scoreboard: tracks in-flight writes in E/M/W and drives the D-stage stall
// plus the D and E forward-mux selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic         clk,
    input  logic         reset,
    hazard_scoreboard_if.slave bus
);
    logic [REG_AW-1:0] wa_e, wa_m, wa_w;
    logic [T_W-1:0]    tnew_e, tnew_m;
    logic [REG_AW-1:0] e_rs, e_rt;
    logic              hz_rs, hz_rt;
    logic              stall;

    hazard_port_check #(.REG_AW(REG_AW), .T_W(T_W)) u_chk_rs (
        .r      (bus.d_rs),
        .tuse   (bus.d_tuse_rs),
        .wa_e   (wa_e),
        .tnew_e (tnew_e),
        .wa_m   (wa_m),
        .tnew_m (tnew_m),
        .wa_w   (wa_w),
        .hz     (hz_rs),
        .fwd    (bus.d_fwd_rs)
    );

    hazard_port_check #(.REG_AW(REG_AW), .T_W(T_W)) u_chk_rt (
        .r      (bus.d_rt),
        .tuse   (bus.d_tuse_rt),
        .wa_e   (wa_e),
        .tnew_e (tnew_e),
        .wa_m   (wa_m),
        .tnew_m (tnew_m),
        .wa_w   (wa_w),
        .hz     (hz_rt),
        .fwd    (bus.d_fwd_rt)
    );

    assign stall     = bus.d_valid && (hz_rs || hz_rt || (bus.d_md && bus.md_busy));
    assign bus.stall = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            wa_e   <= '0;
            wa_m   <= '0;
            wa_w   <= '0;
            tnew_e <= '0;
            tnew_m <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
        end else begin
            wa_w   <= wa_m;
            wa_m   <= wa_e;
            tnew_m <= (tnew_e != '0) ? tnew_e - T_W'(1) : '0;
            if (!stall && bus.d_valid) begin
                wa_e   <= bus.d_wa;
                tnew_e <= bus.d_tnew;
                e_rs   <= bus.d_rs;
                e_rt   <= bus.d_rt;
            end else begin
                wa_e   <= '0;
                tnew_e <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
            end
        end
    end

    // A pending M result with tnew != 0 falls through to W; D already stalled any real conflict.
    always_comb begin
        bus.e_fwd_rs = FWD_GRF;
        bus.e_fwd_rt = FWD_GRF;
        if (e_rs != '0 && wa_m == e_rs && tnew_m == '0) bus.e_fwd_rs = FWD_M;
        else if (e_rs != '0 && wa_w == e_rs)            bus.e_fwd_rs = FWD_W;
        if (e_rt != '0 && wa_m == e_rt && tnew_m == '0) bus.e_fwd_rt = FWD_M;
        else if (e_rt != '0 && wa_w == e_rt)            bus.e_fwd_rt = FWD_W;
    end
endmodule
